// File: rtl/clk_monitor.sv
// Clock-rate monitor: consumes sequence-tagged period counts, checks them against
// limits, and tracks lock, stall and sequence-gap status.
module clk_monitor #(
  parameter int unsigned EST_BITS    = 20,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned TIMEOUT_CYC = 16000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [EST_BITS-1:0] lim_min,
  input  logic [EST_BITS-1:0] lim_max,
  input  logic                cntr_valid,
  input  logic [31:0]         cntr_data,
  output logic                cntr_ready,
  output logic [EST_BITS-1:0] meas_value,
  output logic                meas_strobe,
  output logic                in_range,
  output logic                locked,
  output logic                stalled,
  output logic                missed,
  output logic [7:0]          lost_cnt
);

  localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [2:0] {IDLE, PRIME, ACQUIRE, LOCKED, STALLED} state_t;

  state_t                state;
  logic [3:0]            seq;
  logic [RUN_W-1:0]      run_cnt;
  logic [RUN_W-1:0]      run_inc;
  logic [31:0]           timeout_cnt;

  logic                  transfer;
  logic                  new_meas;
  logic                  meas_ok;
  logic                  seq_skip;
  logic                  timed_out;
  logic [3:0]            in_seq;
  logic [EST_BITS-1:0]   in_count;

  generate
    if (EST_BITS < 28) begin : g_unused
      logic unused_bits;
      assign unused_bits = ^cntr_data[27:EST_BITS];
    end
  endgenerate

  assign in_seq    = cntr_data[31:28];
  assign in_count  = cntr_data[EST_BITS-1:0];
  assign transfer  = cntr_valid & cntr_ready;
  assign new_meas  = transfer && (in_seq != seq) &&
                     (state == ACQUIRE || state == LOCKED || state == STALLED);
  assign meas_ok   = (in_count >= lim_min) && (in_count <= lim_max);
  assign seq_skip  = (in_seq - seq) != 4'd1;
  assign timed_out = (timeout_cnt == TIMEOUT_CYC - 1);

  // Run length saturates at LOCK_CNT; any out-of-range sample restarts it.
  assign run_inc = !meas_ok ? '0 :
                   (run_cnt == RUN_W'(LOCK_CNT)) ? run_cnt : run_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cntr_ready  <= 1'b0;
      seq         <= '0;
      run_cnt     <= '0;
      timeout_cnt <= '0;
      meas_value  <= '0;
      meas_strobe <= 1'b0;
      in_range    <= 1'b0;
      locked      <= 1'b0;
      stalled     <= 1'b0;
      missed      <= 1'b0;
      lost_cnt    <= '0;
    end else begin
      cntr_ready  <= enable;
      meas_strobe <= 1'b0;
      if (!enable) begin
        state       <= IDLE;
        run_cnt     <= '0;
        timeout_cnt <= '0;
        meas_value  <= '0;
        in_range    <= 1'b0;
        locked      <= 1'b0;
        stalled     <= 1'b0;
        missed      <= 1'b0;
        lost_cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            state       <= PRIME;
            timeout_cnt <= '0;
          end
          PRIME: begin
            if (transfer) begin
              seq   <= in_seq;
              state <= ACQUIRE;
            end
          end
          ACQUIRE, LOCKED, STALLED: begin
            // A measurement takes priority over a timeout landing on the same edge.
            if (new_meas) begin
              seq         <= in_seq;
              meas_value  <= in_count;
              in_range    <= meas_ok;
              meas_strobe <= 1'b1;
              timeout_cnt <= '0;
              run_cnt     <= run_inc;
              stalled     <= 1'b0;
              if (seq_skip)
                missed <= 1'b1;
              if (state == LOCKED) begin
                if (!meas_ok) begin
                  state  <= ACQUIRE;
                  locked <= 1'b0;
                  if (lost_cnt != 8'hFF)
                    lost_cnt <= lost_cnt + 8'd1;
                end
              end else if (run_inc == RUN_W'(LOCK_CNT)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end else begin
                state <= ACQUIRE;
              end
            end else if (state != STALLED) begin
              timeout_cnt <= timeout_cnt + 32'd1;
              if (timed_out) begin
                state   <= STALLED;
                stalled <= 1'b1;
                locked  <= 1'b0;
                run_cnt <= '0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_monitor.sv
// Directed bench for clk_monitor: a vector table for the main measurement flow,
// then hand-written sequences for timeout, repeated words, enable drop and reset.
module tb_clk_monitor;

  localparam int unsigned EST_BITS    = 20;
  localparam int unsigned LOCK_CNT    = 4;
  localparam int unsigned TIMEOUT_CYC = 100;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                enable = 1'b0;
  logic [EST_BITS-1:0] lim_min = 20'd1000;
  logic [EST_BITS-1:0] lim_max = 20'd1100;
  logic                cntr_valid = 1'b0;
  logic [31:0]         cntr_data = '0;
  logic                cntr_ready;
  logic [EST_BITS-1:0] meas_value;
  logic                meas_strobe;
  logic                in_range;
  logic                locked;
  logic                stalled;
  logic                missed;
  logic [7:0]          lost_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        en;
    logic        vld;
    logic [3:0]  seq;
    logic [19:0] cnt;
    logic [19:0] lmin;
    logic [19:0] lmax;
    logic        rdy;
    logic        stb;
    logic [19:0] val;
    logic        inr;
    logic        lck;
    logic        stl;
    logic        mis;
    logic [7:0]  lost;
  } vec_t;

  vec_t vecs[$];

  clk_monitor #(
    .EST_BITS    (EST_BITS),
    .LOCK_CNT    (LOCK_CNT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .lim_min     (lim_min),
    .lim_max     (lim_max),
    .cntr_valid  (cntr_valid),
    .cntr_data   (cntr_data),
    .cntr_ready  (cntr_ready),
    .meas_value  (meas_value),
    .meas_strobe (meas_strobe),
    .in_range    (in_range),
    .locked      (locked),
    .stalled     (stalled),
    .missed      (missed),
    .lost_cnt    (lost_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic vld, input logic [3:0] seq,
                              input logic [19:0] cnt, input logic [19:0] lmin,
                              input logic [19:0] lmax, input logic rdy, input logic stb,
                              input logic [19:0] val, input logic inr, input logic lck,
                              input logic stl, input logic mis, input logic [7:0] lost);
    vec_t v;
    v.en = en; v.vld = vld; v.seq = seq; v.cnt = cnt; v.lmin = lmin; v.lmax = lmax;
    v.rdy = rdy; v.stb = stb; v.val = val; v.inr = inr; v.lck = lck; v.stl = stl;
    v.mis = mis; v.lost = lost;
    return v;
  endfunction

  task automatic drive(input logic en, input logic vld, input logic [3:0] seq,
                       input logic [19:0] cnt);
    enable     = en;
    cntr_valid = vld;
    cntr_data  = {seq, 8'hA5, cnt};
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.en, v.vld, v.seq, v.cnt);
    lim_min = v.lmin;
    lim_max = v.lmax;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    cmp($sformatf("v%0d cntr_ready", idx), 32'(cntr_ready), 32'(v.rdy));
    cmp($sformatf("v%0d meas_strobe", idx), 32'(meas_strobe), 32'(v.stb));
    cmp($sformatf("v%0d meas_value", idx), 32'(meas_value), 32'(v.val));
    cmp($sformatf("v%0d in_range", idx), 32'(in_range), 32'(v.inr));
    cmp($sformatf("v%0d locked", idx), 32'(locked), 32'(v.lck));
    cmp($sformatf("v%0d stalled", idx), 32'(stalled), 32'(v.stl));
    cmp($sformatf("v%0d missed", idx), 32'(missed), 32'(v.mis));
    cmp($sformatf("v%0d lost_cnt", idx), 32'(lost_cnt), 32'(v.lost));
  endtask

  task automatic checkAllReset(input string tag);
    cmp({tag, " cntr_ready"}, 32'(cntr_ready), 32'd0);
    cmp({tag, " meas_strobe"}, 32'(meas_strobe), 32'd0);
    cmp({tag, " meas_value"}, 32'(meas_value), 32'd0);
    cmp({tag, " in_range"}, 32'(in_range), 32'd0);
    cmp({tag, " locked"}, 32'(locked), 32'd0);
    cmp({tag, " stalled"}, 32'(stalled), 32'd0);
    cmp({tag, " missed"}, 32'(missed), 32'd0);
    cmp({tag, " lost_cnt"}, 32'(lost_cnt), 32'd0);
  endtask

  initial begin
    int strobes;

    //            en vld seq cnt   lmin  lmax  rdy stb val   inr lck stl mis lost
    vecs.push_back(mk(1, 0, 0,  0,    1000, 1100, 1, 0, 0,    0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1,  1050, 1000, 1100, 1, 0, 0,    0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 2,  1050, 1000, 1100, 1, 1, 1050, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3,  1050, 1000, 1100, 1, 1, 1050, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 4,  1050, 1000, 1100, 1, 1, 1050, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 5,  1050, 1000, 1100, 1, 1, 1050, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 6,  1200, 1000, 1100, 1, 1, 1200, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 7,  1050, 1000, 1100, 1, 1, 1050, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 8,  1050, 1000, 1100, 1, 1, 1050, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 9,  1050, 1000, 1100, 1, 1, 1050, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 10, 1050, 1000, 1100, 1, 1, 1050, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 10, 1050, 1000, 1100, 1, 0, 1050, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 11, 1000, 1000, 1100, 1, 1, 1000, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 12, 1100, 1000, 1100, 1, 1, 1100, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 13, 1101, 1000, 1100, 1, 1, 1101, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 1, 14, 1050, 1100, 1000, 1, 1, 1050, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 1, 15, 1050, 1000, 1100, 1, 1, 1050, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, 1, 0,  1050, 1000, 1100, 1, 1, 1050, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, 1, 1,  1050, 1000, 1100, 1, 1, 1050, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, 1, 2,  1050, 1000, 1100, 1, 1, 1050, 1, 1, 0, 0, 2));
    vecs.push_back(mk(1, 1, 2,  1050, 1000, 1100, 1, 0, 1050, 1, 1, 0, 0, 2));
    vecs.push_back(mk(1, 1, 4,  1050, 1000, 1100, 1, 1, 1050, 1, 1, 0, 1, 2));
    vecs.push_back(mk(1, 0, 4,  1050, 1000, 1100, 1, 0, 1050, 1, 1, 0, 1, 2));
    vecs.push_back(mk(1, 0, 4,  1050, 2000, 3000, 1, 0, 1050, 1, 1, 0, 1, 2));

    repeat (2) @(negedge clk);
    checkAllReset("in_reset");
    rst = 1'b1;
    @(negedge clk);
    cmp("idle cntr_ready", 32'(cntr_ready), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i], i);
    end

    // Timeout from LOCKED: stall lands exactly TIMEOUT_CYC edges after the last measurement.
    lim_min = 20'd1000;
    lim_max = 20'd1100;
    drive(1, 1, 5, 1050);
    @(negedge clk);
    cmp("to_start strobe", 32'(meas_strobe), 32'd1);
    cmp("to_start locked", 32'(locked), 32'd1);
    drive(1, 0, 5, 1050);
    repeat (TIMEOUT_CYC - 1) @(negedge clk);
    cmp("to_edge-1 stalled", 32'(stalled), 32'd0);
    cmp("to_edge-1 locked", 32'(locked), 32'd1);
    @(negedge clk);
    cmp("to_edge stalled", 32'(stalled), 32'd1);
    cmp("to_edge locked", 32'(locked), 32'd0);
    cmp("to_edge lost_cnt", 32'(lost_cnt), 32'd2);
    repeat (5) @(negedge clk);
    cmp("to_hold stalled", 32'(stalled), 32'd1);

    drive(1, 1, 6, 1050);
    @(negedge clk);
    cmp("unstall stalled", 32'(stalled), 32'd0);
    cmp("unstall strobe", 32'(meas_strobe), 32'd1);
    cmp("unstall in_range", 32'(in_range), 32'd1);
    cmp("unstall locked", 32'(locked), 32'd0);
    drive(1, 1, 7, 1050);
    @(negedge clk);
    drive(1, 1, 8, 1050);
    @(negedge clk);
    cmp("relock run3 locked", 32'(locked), 32'd0);
    drive(1, 1, 9, 1050);
    @(negedge clk);
    cmp("relock run4 locked", 32'(locked), 32'd1);

    // Same word held valid: only the first edge is a new measurement.
    drive(1, 1, 10, 1060);
    strobes = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (meas_strobe) strobes++;
    end
    cmp("hold strobes", 32'(strobes), 32'd1);
    cmp("hold meas_value", 32'(meas_value), 32'd1060);
    cmp("hold missed sticky", 32'(missed), 32'd1);

    drive(0, 0, 10, 1060);
    @(negedge clk);
    checkAllReset("disable");

    drive(1, 0, 0, 0);
    @(negedge clk);
    drive(1, 1, 3, 1050);
    @(negedge clk);
    drive(1, 1, 4, 1050);
    @(negedge clk);
    cmp("pre_rst strobe", 32'(meas_strobe), 32'd1);
    cmp("pre_rst meas_value", 32'(meas_value), 32'd1050);
    #2;
    rst = 1'b0;
    #1;
    checkAllReset("async_rst");
    @(negedge clk);
    drive(0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
